// File: rtl/bcd_ascii_converter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bcd_ascii_converter: iterative double-dabble binary to ASCII decimal     |
// | with sign, leading-zero blanking and start/busy/done handshake.          |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module bcd_ascii_converter #(
  parameter int         WIDTH      = 16,
  parameter int         DIGITS     = 5,
  parameter logic [7:0] BLANK_CHAR = 8'h20
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [WIDTH-1:0]       data_bus,
  input  logic                   signed_mode,
  input  logic                   blank_zeros,
  output logic                   busy,
  output logic                   done,
  output logic [DIGITS-1:0][7:0] bcd_ascii_digits,
  output logic [7:0]             sign_ascii
);

  // ceil(WIDTH * log10(2)) in integer arithmetic
  localparam int c_MIN_DIGITS = (WIDTH * 30103 + 99999) / 100000;
  localparam int c_BCD_W      = 4 * DIGITS;
  localparam int c_CNT_W      = $clog2(WIDTH + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_INIT = c_CNT_W'(WIDTH);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

  generate
    if (WIDTH < 2) begin : g_width_check
      $error("bcd_ascii_converter: WIDTH must be >= 2");
    end
    if (DIGITS < c_MIN_DIGITS) begin : g_digits_check
      $error("bcd_ascii_converter: DIGITS too small for WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_FORMAT = 2'd2
  } state_t;

  state_t               r_state;
  logic [c_BCD_W-1:0]   r_bcd;
  logic [WIDTH-1:0]     r_mag;
  logic [c_CNT_W-1:0]   r_count;
  logic                 r_neg;
  logic                 r_blank;

  logic                   w_neg;
  logic [WIDTH-1:0]       w_mag;
  logic [c_BCD_W-1:0]     w_adj;
  logic [DIGITS-1:0][7:0] w_digits;
  logic                   w_lead;

  assign w_neg = signed_mode & data_bus[WIDTH-1];
  assign w_mag = w_neg ? (~data_bus + WIDTH'(1)) : data_bus;

  generate
    for (genvar i = 0; i < DIGITS; i++) begin : g_adj
      assign w_adj[4*i +: 4] = (r_bcd[4*i +: 4] >= 4'd5) ? (r_bcd[4*i +: 4] + 4'd3)
                                                          : r_bcd[4*i +: 4];
    end
  endgenerate

  // Blanking walks down from the top digit until the first nonzero one; digit 0 always shows.
  always_comb begin
    w_lead   = r_blank;
    w_digits = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (w_lead && (r_bcd[4*i +: 4] == 4'd0)) begin
        w_digits[i] = BLANK_CHAR;
      end else begin
        w_lead      = 1'b0;
        w_digits[i] = 8'h30 + {4'd0, r_bcd[4*i +: 4]};
      end
    end
    w_digits[0] = 8'h30 + {4'd0, r_bcd[3:0]};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state          <= ST_IDLE;
      r_bcd            <= '0;
      r_mag            <= '0;
      r_count          <= '0;
      r_neg            <= 1'b0;
      r_blank          <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      bcd_ascii_digits <= {DIGITS{8'h30}};
      sign_ascii       <= 8'h20;
    end else begin
      done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_neg   <= w_neg;
            r_blank <= blank_zeros;
            r_mag   <= w_mag;
            r_bcd   <= '0;
            r_count <= c_CNT_INIT;
            busy    <= 1'b1;
            r_state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          {r_bcd, r_mag} <= {w_adj, r_mag} << 1;
          r_count        <= r_count - c_CNT_ONE;
          if (r_count == c_CNT_ONE) begin
            r_state <= ST_FORMAT;
          end
        end
        ST_FORMAT: begin
          bcd_ascii_digits <= w_digits;
          sign_ascii       <= r_neg ? 8'h2D : 8'h20;
          done             <= 1'b1;
          busy             <= 1'b0;
          r_state          <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bcd_ascii_converter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_bcd_ascii_converter: self-checking bench with cycle-level model.       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_bcd_ascii_converter;

  logic            clk         = 1'b0;
  logic            reset       = 1'b0;
  logic            start       = 1'b0;
  logic [15:0]     data_bus    = '0;
  logic            signed_mode = 1'b0;
  logic            blank_zeros = 1'b0;
  logic            busy, done;
  logic [4:0][7:0] digits;
  logic [7:0]      sign;

  logic            b8_start  = 1'b0;
  logic [7:0]      b8_data   = '0;
  logic            b8_signed = 1'b0;
  logic            b8_blank  = 1'b0;
  logic            b8_busy, b8_done;
  logic [2:0][7:0] b8_digits;
  logic [7:0]      b8_sign;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  bcd_ascii_converter #(.WIDTH(16), .DIGITS(5), .BLANK_CHAR(8'h20)) dut (
    .clk(clk), .reset(reset), .start(start), .data_bus(data_bus),
    .signed_mode(signed_mode), .blank_zeros(blank_zeros),
    .busy(busy), .done(done), .bcd_ascii_digits(digits), .sign_ascii(sign)
  );

  bcd_ascii_converter #(.WIDTH(8), .DIGITS(3), .BLANK_CHAR(8'h20)) dut8 (
    .clk(clk), .reset(reset), .start(b8_start), .data_bus(b8_data),
    .signed_mode(b8_signed), .blank_zeros(b8_blank),
    .busy(b8_busy), .done(b8_done), .bcd_ascii_digits(b8_digits), .sign_ascii(b8_sign)
  );

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Decimal rendering from plain arithmetic.
  function automatic void fmt(input logic [15:0] d, input int w, input int nd, input bit s,
                              input bit b, output logic [39:0] digs, output logic [7:0] sg);
    longint unsigned v;
    bit neg;
    v   = 64'(d) & ((64'd1 << w) - 64'd1);
    neg = s && (((v >> (w - 1)) & 64'd1) == 64'd1);
    if (neg) v = (64'd1 << w) - v;
    digs = '0;
    for (int i = 0; i < nd; i++) begin
      digs[i*8 +: 8] = 8'h30 + 8'(v % 10);
      v = v / 10;
    end
    if (b) begin
      for (int i = nd - 1; i >= 1; i--) begin
        if (digs[i*8 +: 8] != 8'h30) break;
        digs[i*8 +: 8] = 8'h20;
      end
    end
    sg = neg ? 8'h2D : 8'h20;
  endfunction

  // Model: an accepted request completes 17 edges later; outputs change only then.
  logic        m_busy   = 1'b0;
  logic        m_done   = 1'b0;
  logic [39:0] m_digits = "00000";
  logic [7:0]  m_sign   = 8'h20;
  int          m_cnt    = 0;
  logic [39:0] m_pend_d = '0;
  logic [7:0]  m_pend_s = '0;
  logic [39:0] m_tmp_d;
  logic [7:0]  m_tmp_s;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_busy   <= 1'b0;
      m_done   <= 1'b0;
      m_digits <= "00000";
      m_sign   <= 8'h20;
      m_cnt    <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        if (m_cnt == 16) begin
          m_busy   <= 1'b0;
          m_done   <= 1'b1;
          m_digits <= m_pend_d;
          m_sign   <= m_pend_s;
        end
        m_cnt <= m_cnt + 1;
      end else if (start) begin
        fmt(data_bus, 16, 5, signed_mode, blank_zeros, m_tmp_d, m_tmp_s);
        m_pend_d <= m_tmp_d;
        m_pend_s <= m_tmp_s;
        m_busy   <= 1'b1;
        m_cnt    <= 0;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("busy",   48'(busy),   48'(m_busy));
      check("done",   48'(done),   48'(m_done));
      check("digits", 48'(digits), 48'(m_digits));
      check("sign",   48'(sign),   48'(m_sign));
    end
  end

  task automatic do_conv(input logic [15:0] d, input bit s, input bit b);
    int lat;
    for (int i = 0; i < 40 && busy; i++) @(negedge clk);
    @(negedge clk);
    data_bus = d; signed_mode = s; blank_zeros = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; data_bus = 16'($urandom); signed_mode = 1'($urandom); blank_zeros = 1'($urandom);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      if (done) begin lat = k - 1; break; end
      @(negedge clk);
    end
    check("latency", 48'(lat), 48'(17));
  endtask

  task automatic b8_conv(input logic [7:0] d, input bit s, input bit b);
    int seen;
    @(negedge clk);
    b8_data = d; b8_signed = s; b8_blank = b; b8_start = 1'b1;
    @(negedge clk);
    b8_start = 1'b0; b8_data = 8'($urandom);
    seen = 0;
    for (int k = 1; k <= 30; k++) begin
      if (b8_done) begin seen = k - 1; break; end
      @(negedge clk);
    end
    check("b8_latency", 48'(seen), 48'(9));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [39:0] pd;
    logic [7:0]  ps;
    int busy_cnt, ndone, nb2b;

    // Model pins against hand-computed strings.
    fmt(16'hFFFF, 16, 5, 1'b1, 1'b1, pd, ps);
    check("pin_neg1_blank", {pd, ps}, {"    1", 8'h2D});
    fmt(16'd1200, 16, 5, 1'b0, 1'b1, pd, ps);
    check("pin_1200_blank", {pd, ps}, {" 1200", 8'h20});

    repeat (2) @(negedge clk);
    cmp_en = 1'b1;
    check("rst_busy",   48'(busy),   48'(0));
    check("rst_done",   48'(done),   48'(0));
    check("rst_digits", 48'(digits), 48'("00000"));
    check("rst_sign",   48'(sign),   48'(8'h20));
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    do_conv(16'd0, 1'b0, 1'b0);
    check("zero",     {digits, sign}, {"00000", 8'h20});
    do_conv(16'd65535, 1'b0, 1'b0);
    check("max",      {digits, sign}, {"65535", 8'h20});
    do_conv(16'd1234, 1'b0, 1'b1);
    check("1234_blk", {digits, sign}, {" 1234", 8'h20});
    do_conv(16'h8000, 1'b1, 1'b0);
    check("minneg",   {digits, sign}, {"32768", 8'h2D});
    do_conv(16'hFFFF, 1'b1, 1'b0);
    check("neg1",     {digits, sign}, {"00001", 8'h2D});
    do_conv(16'hFFFF, 1'b1, 1'b1);
    check("neg1_blk", {digits, sign}, {"    1", 8'h2D});
    do_conv(16'd0, 1'b1, 1'b1);
    check("zero_blk", {digits, sign}, {"    0", 8'h20});

    // Starts while busy are dropped.
    @(negedge clk);
    data_bus = 16'd4321; signed_mode = 1'b0; blank_zeros = 1'b0; start = 1'b1;
    busy_cnt = 0; ndone = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      start = (k == 3 || k == 9);
      if (k == 3 || k == 9) data_bus = 16'd999;
      if (busy) busy_cnt++;
      if (done) ndone++;
    end
    check("ign_busy_cycles", 48'(busy_cnt), 48'(17));
    check("ign_done_count",  48'(ndone),    48'(1));
    check("ign_result",      {digits, sign}, {"04321", 8'h20});

    // Start held high: a new operand is presented at every done.
    @(negedge clk);
    data_bus = 16'($urandom); signed_mode = 1'($urandom); blank_zeros = 1'($urandom); start = 1'b1;
    nb2b = 0;
    for (int c = 0; c < 200 && nb2b < 5; c++) begin
      @(negedge clk);
      if (done) begin
        nb2b++;
        data_bus = 16'($urandom); signed_mode = 1'($urandom); blank_zeros = 1'($urandom);
      end
    end
    start = 1'b0;
    check("b2b_count", 48'(nb2b), 48'(5));
    repeat (20) @(negedge clk);

    // Reset in the middle of the shift phase.
    @(negedge clk);
    data_bus = 16'd1234; signed_mode = 1'b0; blank_zeros = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("abort_busy",   48'(busy),   48'(0));
    check("abort_done",   48'(done),   48'(0));
    check("abort_digits", 48'(digits), 48'("00000"));
    repeat (2) @(negedge clk);
    reset = 1'b1;
    ndone = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("abort_no_done", 48'(ndone), 48'(0));
    do_conv(16'd42, 1'b0, 1'b0);
    check("after_abort", {digits, sign}, {"00042", 8'h20});

    // Randomised conversions, checked every cycle by the model.
    for (int n = 0; n < 40; n++) begin
      do_conv(16'($urandom), 1'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // Narrow instance.
    b8_conv(8'd255, 1'b0, 1'b0);
    check("b8_255", {b8_digits, b8_sign}, {"255", 8'h20});
    b8_conv(8'h80, 1'b1, 1'b0);
    check("b8_m128", {b8_digits, b8_sign}, {"128", 8'h2D});
    b8_conv(8'd7, 1'b0, 1'b1);
    check("b8_7_blk", {b8_digits, b8_sign}, {"  7", 8'h20});
    for (int n = 0; n < 12; n++) begin
      logic [7:0] rd;
      bit rs, rb;
      rd = 8'($urandom); rs = 1'($urandom); rb = 1'($urandom);
      b8_conv(rd, rs, rb);
      fmt({8'd0, rd}, 8, 3, rs, rb, pd, ps);
      check("b8_random", {b8_digits, b8_sign}, {pd[23:0], ps});
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
